// File: rtl/bp_be_branch_resolver_pkg.sv
// bp_be_pkg: shared types for the backend branch resolver and its in-flight queue
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_DECLARE_INFLIGHT_ENTRY_S(eaddr_width_mp, mdw_mp) \
  typedef struct packed { \
    logic [eaddr_width_mp-1:0] pc; \
    logic                      predict; \
    logic [eaddr_width_mp-1:0] target; \
    logic [mdw_mp-1:0]         metadata; \
  } bp_be_inflight_entry_s

`define BP_BE_INFLIGHT_ENTRY_WIDTH(eaddr_width_mp, mdw_mp) (2*(eaddr_width_mp)+1+(mdw_mp))

package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_attaboy_send,
    e_redirect_send
  } bp_be_resolver_state_e;

endpackage

`endif

// File: rtl/bp_be_branch_resolver_inflight_queue.sv
// bp_be_inflight_queue: circular FIFO of in-flight branch entries with clear and occupancy count
module bp_be_inflight_queue #(
    parameter int width_p = 1,
    parameter int els_p   = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   clear_i,
    input  logic                   enq_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   deq_i,
    output logic [width_p-1:0]     data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(els_p):0] count_o
);
    localparam int lg_lp = $clog2(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [lg_lp:0]     wptr, rptr;
    logic               enq, deq;

    // clear dominates, so a same-cycle enqueue or dequeue is dropped
    assign enq     = enq_i & ~full_o & ~clear_i;
    assign deq     = deq_i & ~empty_o & ~clear_i;
    assign empty_o = wptr == rptr;
    assign full_o  = (wptr[lg_lp] != rptr[lg_lp]) & (wptr[lg_lp-1:0] == rptr[lg_lp-1:0]);
    assign count_o = wptr - rptr;
    assign data_o  = mem[rptr[lg_lp-1:0]];

    // pointer update: wrap bit distinguishes full from empty
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq) wptr <= wptr + (lg_lp+1)'(1);
            if (deq) rptr <= rptr + (lg_lp+1)'(1);
        end
    end

    // entry storage needs no reset; validity is carried by the pointers
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr[lg_lp-1:0]] <= data_i;
    end
endmodule

// File: rtl/bp_be_branch_resolver.sv
// bp_be_branch_resolver: compares predictions against execute outcomes and returns attaboy/redirect commands to the FE
module bp_be_branch_resolver #(
  parameter int eaddr_width_p    = 64,
  parameter int btb_indx_width_p = 9,
  parameter int bht_indx_width_p = 5,
  parameter int ras_addr_width_p = 22,
  parameter int inflight_els_p   = 8,
  localparam int mdw = btb_indx_width_p + bht_indx_width_p + ras_addr_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            fetch_v_i,
  output logic                            fetch_ready_o,
  input  logic [eaddr_width_p-1:0]        fetch_pc_i,
  input  logic                            fetch_predict_i,
  input  logic [eaddr_width_p-1:0]        fetch_target_i,
  input  logic [mdw-1:0]                  fetch_metadata_i,
  input  logic                            resolve_v_i,
  output logic                            resolve_ready_o,
  input  logic                            resolve_taken_i,
  input  logic [eaddr_width_p-1:0]        resolve_target_i,
  input  logic                            flush_i,
  output logic                            cmd_v_o,
  input  logic                            cmd_ready_i,
  output logic                            cmd_attaboy_o,
  output logic [eaddr_width_p-1:0]        cmd_pc_o,
  output logic [mdw-1:0]                  cmd_metadata_o,
  output logic [$clog2(inflight_els_p):0] inflight_count_o,
  output logic                            err_o
);
  import bp_be_pkg::*;

  `BP_BE_DECLARE_INFLIGHT_ENTRY_S(eaddr_width_p, mdw);

  bp_be_inflight_entry_s    fetch_entry, head;
  bp_be_resolver_state_e    state, state_n;
  logic                     full, empty, res_acc, pop, mispredict, clear;
  logic [eaddr_width_p-1:0] next_pc;

  assign fetch_entry     = '{pc: fetch_pc_i, predict: fetch_predict_i, target: fetch_target_i, metadata: fetch_metadata_i};
  assign fetch_ready_o   = ~full & (state != e_redirect_send);
  assign resolve_ready_o = state == e_idle;
  assign res_acc         = resolve_v_i & resolve_ready_o & ~flush_i;
  assign pop             = res_acc & ~empty;
  assign mispredict      = (head.predict != resolve_taken_i)
                         | (head.predict & resolve_taken_i & (head.target != resolve_target_i));
  assign next_pc         = resolve_taken_i ? resolve_target_i : head.pc + eaddr_width_p'(4);
  assign clear           = flush_i | (pop & mispredict);
  assign cmd_v_o         = state != e_idle;
  assign cmd_attaboy_o   = state == e_attaboy_send;

  bp_be_inflight_queue #(
    .width_p(`BP_BE_INFLIGHT_ENTRY_WIDTH(eaddr_width_p, mdw)),
    .els_p  (inflight_els_p)
  ) queue (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (clear),
    .enq_i    (fetch_v_i & fetch_ready_o),
    .data_i   (fetch_entry),
    .deq_i    (pop),
    .data_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (inflight_count_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= e_idle;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state == e_idle) state_n = pop ? (mispredict ? e_redirect_send : e_attaboy_send) : e_idle;
    else if (cmd_ready_i) state_n = e_idle;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_pc_o       <= '0;
      cmd_metadata_o <= '0;
    end else if (pop) begin
      cmd_pc_o       <= mispredict ? next_pc : '0;
      cmd_metadata_o <= head.metadata;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)           err_o <= 1'b0;
    else if (res_acc & empty) err_o <= 1'b1;
  end
endmodule

// File: tb/tb_bp_be_branch_resolver.sv
// tb_bp_be_branch_resolver: directed vectors with a command scoreboard checked by an independent monitor
module tb_bp_be_branch_resolver;
    localparam int ew  = 64;
    localparam int mdw = 36;

    logic           clk_i = 0, reset_n_i = 0;
    logic           fetch_v_i = 0, fetch_predict_i = 0, resolve_v_i = 0, resolve_taken_i = 0;
    logic           flush_i = 0, cmd_ready_i = 1;
    logic [ew-1:0]  fetch_pc_i = '0, fetch_target_i = '0, resolve_target_i = '0;
    logic [mdw-1:0] fetch_metadata_i = '0;
    logic           fetch_ready_o, resolve_ready_o, cmd_v_o, cmd_attaboy_o, err_o;
    logic [ew-1:0]  cmd_pc_o;
    logic [mdw-1:0] cmd_metadata_o;
    logic [3:0]     inflight_count_o;

    typedef struct {
        logic           att;
        logic [ew-1:0]  pc;
        logic [mdw-1:0] md;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;

    bp_be_branch_resolver dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .fetch_v_i(fetch_v_i), .fetch_ready_o(fetch_ready_o), .fetch_pc_i(fetch_pc_i),
        .fetch_predict_i(fetch_predict_i), .fetch_target_i(fetch_target_i),
        .fetch_metadata_i(fetch_metadata_i),
        .resolve_v_i(resolve_v_i), .resolve_ready_o(resolve_ready_o),
        .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
        .flush_i(flush_i), .cmd_v_o(cmd_v_o), .cmd_ready_i(cmd_ready_i),
        .cmd_attaboy_o(cmd_attaboy_o), .cmd_pc_o(cmd_pc_o), .cmd_metadata_o(cmd_metadata_o),
        .inflight_count_o(inflight_count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: every delivered command must match the oldest expected one
    always @(negedge clk_i) begin
        if (reset_n_i && cmd_v_o && cmd_ready_i) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_cmd: got attaboy=%0b pc=%0h md=%0h expected none", cmd_attaboy_o, cmd_pc_o, cmd_metadata_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cmd_attaboy", cmd_attaboy_o, e.att);
                chk("cmd_pc", cmd_pc_o, e.pc);
                chk("cmd_metadata", cmd_metadata_o, e.md);
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input logic [ew-1:0] pc, input logic pr, input logic [ew-1:0] tg, input logic [mdw-1:0] md);
        fetch_v_i = 1; fetch_pc_i = pc; fetch_predict_i = pr; fetch_target_i = tg; fetch_metadata_i = md;
        tick;
        fetch_v_i = 0;
    endtask

    task automatic resolve(input logic tk, input logic [ew-1:0] tg, input logic att, input logic [ew-1:0] pc, input logic [mdw-1:0] md);
        sb.push_back('{att, pc, md});
        resolve_v_i = 1; resolve_taken_i = tk; resolve_target_i = tg;
        tick;
        resolve_v_i = 0;
        chk("cmd_v_latency", cmd_v_o, 1);
        tick;
    endtask

    task automatic fetch_n(input int i);
        fetch(64'h100 + 64'(4*i), i[0], 64'h8000 + 64'(i), mdw'(i));
    endtask

    task automatic resolve_n(input int i);
        resolve(i[0], 64'h8000 + 64'(i), 1, 0, mdw'(i));
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1;
        chk("rst_fetch_ready", fetch_ready_o, 1);
        chk("rst_resolve_ready", resolve_ready_o, 1);
        chk("rst_cmd_v", cmd_v_o, 0);
        chk("rst_count", inflight_count_o, 0);
        chk("rst_err", err_o, 0);

        fetch(64'h1000, 1, 64'h2000, 36'h5A);
        chk("t1_count_1", inflight_count_o, 1);
        resolve(1, 64'h2000, 1, 0, 36'h5A);
        chk("t1_count_0", inflight_count_o, 0);

        fetch(64'h1000, 1, 64'h2000, 36'h11);
        fetch(64'h1004, 0, 64'h0, 36'h22);
        chk("t2_count_2", inflight_count_o, 2);
        sb.push_back('{1'b0, 64'h1004, 36'h11});
        resolve_v_i = 1; resolve_taken_i = 0; resolve_target_i = 0;
        tick;
        resolve_v_i = 0;
        chk("t2_cleared", inflight_count_o, 0);
        chk("t2_fetch_ready_redirect", fetch_ready_o, 0);
        tick;
        chk("t2_idle_fetch_ready", fetch_ready_o, 1);

        fetch(64'h1000, 1, 64'h2000, 36'h33);
        cmd_ready_i = 0;
        sb.push_back('{1'b0, 64'h3000, 36'h33});
        resolve_v_i = 1; resolve_taken_i = 1; resolve_target_i = 64'h3000;
        tick;
        resolve_v_i = 0;
        for (int c = 0; c < 3; c++) begin
            chk("t3_hold_v", cmd_v_o, 1);
            chk("t3_hold_att", cmd_attaboy_o, 0);
            chk("t3_hold_pc", cmd_pc_o, 64'h3000);
            chk("t3_hold_md", cmd_metadata_o, 36'h33);
            chk("t3_resolve_ready", resolve_ready_o, 0);
            chk("t3_fetch_ready", fetch_ready_o, 0);
            tick;
        end
        cmd_ready_i = 1;
        tick;
        chk("t3_idle", cmd_v_o, 0);

        for (int i = 0; i < 8; i++) fetch_n(i);
        chk("t4_full_ready", fetch_ready_o, 0);
        chk("t4_full_count", inflight_count_o, 8);
        fetch_n(99);
        chk("t4_full_drop", inflight_count_o, 8);
        resolve_n(0);
        chk("t4_ready_again", fetch_ready_o, 1);
        chk("t4_count_7", inflight_count_o, 7);
        for (int k = 1; k < 8; k++) begin
            fetch_n(7 + k);
            resolve_n(k);
        end
        fetch_n(15);
        for (int k = 8; k < 16; k++) resolve_n(k);
        chk("t4_drained", inflight_count_o, 0);

        resolve_v_i = 1; resolve_taken_i = 0;
        tick;
        resolve_v_i = 0;
        chk("t5_err_set", err_o, 1);
        chk("t5_no_cmd", cmd_v_o, 0);
        tick;
        chk("t5_err_sticky", err_o, 1);
        for (int i = 0; i < 3; i++) fetch_n(i);
        chk("t5_count_3", inflight_count_o, 3);
        flush_i = 1;
        fetch_v_i = 1;
        tick;
        flush_i = 0;
        fetch_v_i = 0;
        chk("t5_flush_count", inflight_count_o, 0);

        fetch_n(2);
        flush_i = 1; resolve_v_i = 1; resolve_taken_i = 1; resolve_target_i = 64'h8002;
        tick;
        flush_i = 0; resolve_v_i = 0;
        chk("t5_flush_wins_cmd", cmd_v_o, 0);
        chk("t5_flush_wins_count", inflight_count_o, 0);

        fetch_n(4);
        cmd_ready_i = 0;
        sb.push_back('{1'b1, 64'h0, 36'h4});
        resolve_v_i = 1; resolve_taken_i = 0;
        tick;
        resolve_v_i = 0;
        flush_i = 1;
        tick;
        flush_i = 0;
        chk("t5_pending_kept", cmd_v_o, 1);
        cmd_ready_i = 1;
        tick;

        fetch_n(6);
        fetch_n(8);
        cmd_ready_i = 0;
        resolve_v_i = 1; resolve_taken_i = 1; resolve_target_i = 64'h4444;
        tick;
        resolve_v_i = 0;
        chk("t6_redirect_pending", cmd_v_o, 1);
        #2 reset_n_i = 0;
        #1;
        chk("t6_async_cmd_v", cmd_v_o, 0);
        chk("t6_async_count", inflight_count_o, 0);
        tick;
        cmd_ready_i = 1;
        reset_n_i = 1;
        tick;
        chk("t6_fetch_ready", fetch_ready_o, 1);
        chk("t6_resolve_ready", resolve_ready_o, 1);
        chk("t6_err_cleared", err_o, 0);

        chk("sb_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
